// File: rtl/dmem_responder.sv
// Data-memory responder: 256 x 32-bit word store behind an IDLE/ACCESS/RESP handshake.
// Optional misalignment faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] valM,
   output logic        dmem_error,
   output logic        busy,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q;
   logic        rd_q;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        resp_valid_q;
   logic        err_q;
   logic [31:0] valm_q;
   logic [7:0]  err_cnt_q;
   logic [31:0] mem_q [256];

   logic        fault_d;
   logic        store_d;
   logic [7:0]  idx_d;

`ifdef DMEM_ALIGN_CHECK_EN
   always_comb begin
      idx_d   = addr_q[9:2];
      fault_d = (|addr_q[31:10]) | (rd_q & wr_q) | (|addr_q[1:0]);
      store_d = (state_q == ACCESS) & wr_q & ~fault_d & ~rst;
   end
`else
   logic align_unused;
   assign align_unused = |addr_q[1:0];

   always_comb begin
      idx_d   = addr_q[9:2];
      fault_d = (|addr_q[31:10]) | (rd_q & wr_q);
      store_d = (state_q == ACCESS) & wr_q & ~fault_d & ~rst;
   end
`endif

   // Storage is deliberately outside reset; rst only gates the write strobe.
   always_ff @(posedge clk) begin
      if (store_d) begin
         mem_q[idx_d] <= wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         valm_q       <= '0;
         err_q        <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               resp_valid_q <= 1'b0;
               if (req_valid) begin
                  rd_q    <= read;
                  wr_q    <= write;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               resp_valid_q <= 1'b1;
               err_q        <= fault_d;
               valm_q       <= (rd_q & ~wr_q & ~fault_d) ? mem_q[idx_d] : '0;
               state_q      <= RESP;
            end
            RESP: begin
               resp_valid_q <= 1'b0;
               if (err_q && (err_cnt_q != '1)) begin
                  err_cnt_q <= err_cnt_q + 8'd1;
               end
               state_q <= IDLE;
            end
            default: begin
               resp_valid_q <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = ~req_ready;
   assign resp_valid = resp_valid_q;
   assign valM       = valm_q;
   assign dmem_error = err_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, multi-cycle corner sequences,
// and randomized traffic against a word-array reference model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        resp_valid;
   logic [31:0] valM;
   logic        dmem_error;
   logic        busy;
   logic [7:0]  err_count;

   dmem_responder dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .read(read), .write(write), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .valM(valM), .dmem_error(dmem_error),
      .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: plain word array plus saturating fault counter.
   logic [31:0] mmem [256];
   int unsigned mcnt = 0;

   task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] ev, output bit ee);
      bit fault;
      fault = (a >= 32'd1024) || (rd && wr);
`ifdef DMEM_ALIGN_CHECK_EN
      if (a % 4 != 0) fault = 1;
`endif
      ev = '0;
      ee = fault;
      if (fault) begin
         if (mcnt < 255) mcnt++;
      end else if (wr) begin
         mmem[(a / 4) % 256] = wd;
      end else if (rd) begin
         ev = mmem[(a / 4) % 256];
      end
   endtask

   // Continuous handshake sanity checks.
   logic prev_rv = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
         if (prev_rv) chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
      end
      prev_rv = resp_valid;
   end

   // Issue one request from IDLE; req_valid stays high with junk inputs while busy.
   task automatic run_op(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ev, input bit ee);
      int lat;
      bit seen;
      logic [31:0] got_v;
      logic        got_e;
      chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
      read = rd; write = wr; addr = a; wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      seen = 0;
      for (lat = 1; lat <= 6; lat++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1;
            req_valid = 1'b0;
            break;
         end
         read = 1'($urandom); write = 1'($urandom); addr = $urandom; wdata = $urandom;
      end
      req_valid = 1'b0;
      if (!seen) begin
         chk({nm, "_resp_timeout"}, 32'd0, 32'd1);
         return;
      end
      got_v = valM; got_e = dmem_error;
      chk({nm, "_latency"}, lat, 32'd2);
      chk({nm, "_valM"}, got_v, ev);
      chk({nm, "_err"}, {31'd0, got_e}, {31'd0, ee});
      @(negedge clk);
      chk({nm, "_rv_low"}, {31'd0, resp_valid}, 32'd0);
      chk({nm, "_valM_hold"}, valM, ev);
      chk({nm, "_err_hold"}, {31'd0, dmem_error}, {31'd0, ee});
      chk({nm, "_errcnt"}, {24'd0, err_count}, mcnt);
   endtask

   task automatic model_op(input string nm, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] ev;
      bit ee;
      model_apply(rd, wr, a, wd, ev, ee);
      run_op(nm, rd, wr, a, wd, ev, ee);
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] ev;
      bit          ee;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [31:0] dv;
      bit          de;
      int          acc;
      int          rsp;

      tbl[0]  = '{0, 1, 32'h10,       32'hDEADBEEF, 32'h0,        0};
      tbl[1]  = '{1, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0};
      tbl[2]  = '{1, 0, 32'h400,      32'h0,        32'h0,        1};
      tbl[3]  = '{0, 1, 32'h20,       32'h5,        32'h0,        0};
      tbl[4]  = '{1, 1, 32'h20,       32'h77,       32'h0,        1};
      tbl[5]  = '{1, 0, 32'h20,       32'h0,        32'h5,        0};
      tbl[6]  = '{0, 0, 32'h10,       32'h99,       32'h0,        0};
      tbl[7]  = '{0, 1, 32'h4,        32'h12345678, 32'h0,        0};
`ifdef DMEM_ALIGN_CHECK_EN
      tbl[8]  = '{1, 0, 32'h6,        32'h0,        32'h0,        1};
`else
      tbl[8]  = '{1, 0, 32'h6,        32'h0,        32'h12345678, 0};
`endif
      tbl[9]  = '{1, 0, 32'hFFFFFFF0, 32'h0,        32'h0,        1};
      tbl[10] = '{0, 1, 32'h3FC,      32'hA5A5A5A5, 32'h0,        0};
      tbl[11] = '{1, 0, 32'h3FC,      32'h0,        32'hA5A5A5A5, 0};
`ifdef DMEM_ALIGN_CHECK_EN
      tbl[12] = '{1, 0, 32'h3FF,      32'h0,        32'h0,        1};
`else
      tbl[12] = '{1, 0, 32'h3FF,      32'h0,        32'hA5A5A5A5, 0};
`endif
      for (int i = 0; i < 256; i++) mmem[i] = '0;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_valM", valM, 32'd0);
      chk("rst_err", {31'd0, dmem_error}, 32'd0);
      chk("rst_errcnt", {24'd0, err_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 13; i++) begin
         model_apply(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, dv, de);
         run_op($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
                tbl[i].ev, tbl[i].ee);
      end

      // Back-to-back loads with req_valid held for 9 cycles
      acc = 0; rsp = 0;
      read = 1'b1; write = 1'b0; addr = 32'h10; req_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         chk($sformatf("b2b_ready%0d", c), {31'd0, req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("b2b_rv%0d", c), {31'd0, resp_valid}, (c % 3 == 2) ? 32'd1 : 32'd0);
         if (req_ready && req_valid) acc++;
         if (resp_valid) begin
            rsp++;
            chk($sformatf("b2b_valM%0d", c), valM, 32'hDEADBEEF);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", acc, 32'd3);
      chk("b2b_resps", rsp, 32'd3);
      repeat (2) @(negedge clk);

      // Reset during ACCESS of a store, and at the accepting edge
      model_op("raw_pre", 0, 1, 32'h8, 32'h1);
      read = 1'b0; write = 1'b1; addr = 32'h8; wdata = 32'h2; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_acc_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1; req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mcnt = 0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("abort_acc_norsp%0d", c), {31'd0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      chk("abort_acc_errcnt", {24'd0, err_count}, 32'd0);
      read = 1'b0; write = 1'b1; addr = 32'h8; wdata = 32'h3; req_valid = 1'b1; rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("abort_idle_ready%0d", c), {31'd0, req_ready}, 32'd1);
         chk($sformatf("abort_idle_norsp%0d", c), {31'd0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      run_op("raw_post", 1, 0, 32'h8, 32'h0, 32'h1, 0);

      // Fill every word so random loads have defined data
      for (int i = 0; i < 256; i++) begin
         model_op("fill", 0, 1, i * 4, 32'h0101_0101 * i ^ 32'h5A00_0000);
      end

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         bit rd, wr;
         if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
         else a = $urandom_range(0, 1023);
         rd = 1'($urandom); wr = 1'($urandom);
         model_op($sformatf("rnd%0d", i), rd, wr, a, $urandom);
      end

      // Error-count saturation
      for (int i = 0; i < 260; i++) begin
         model_op("sat", 1, 0, 32'h400, 32'h0);
      end
      chk("sat_final", {24'd0, err_count}, 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0x0, expected 0x1");
      $fatal(1, "timeout");
   end

endmodule
